// File: rtl/menu_ctrl_if.sv
// Menu controller bus: raw pushbuttons and the game_over level go into the
// controller, and the registered menu state comes out to the page renderers.
interface menu_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_enter;
  logic       game_over;
  logic       up;
  logic       speed;
  logic [1:0] hard;
  logic [1:0] page;
  logic       start;

  // Board/stimulus side: drives buttons and game_over, observes menu state
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_enter, game_over,
    input  up, speed, hard, page, start
  );

  // Controller side
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_enter, game_over,
    output up, speed, hard, page, start
  );
endinterface

// File: rtl/menu_ctrl.sv
// Menu controller for the game front end.
// Debounces five pushbuttons with DB_LEN-sample shift registers, turns each
// accepted press into a single-cycle event, and runs the MENU/PLAY/OVER page
// state machine with the cursor, speed and difficulty settings.
// Optional build macro: MENU_CTRL_HARD_WRAP_EN -- when defined, difficulty
// wraps around at both ends of its range; otherwise it saturates.
module menu_ctrl #(
  parameter int DB_LEN = 4
) (
  input  logic          clk_22,
  input  logic          rst,
  menu_ctrl_if.slave    bus
);

  // Button slots, listed in decreasing priority
  localparam int B_ENTER = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;
  localparam int NBTN    = 5;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Difficulty step up, with wrap or saturation at the top of the range
  function automatic logic [1:0] hard_inc(input logic [1:0] h);
`ifdef MENU_CTRL_HARD_WRAP_EN
    hard_inc = (h >= 2'd2) ? 2'd0 : h + 2'd1;
`else
    hard_inc = (h >= 2'd2) ? 2'd2 : h + 2'd1;
`endif
  endfunction

  // Difficulty step down, with wrap or saturation at the bottom of the range
  function automatic logic [1:0] hard_dec(input logic [1:0] h);
`ifdef MENU_CTRL_HARD_WRAP_EN
    hard_dec = (h == 2'd0) ? 2'd2 : h - 2'd1;
`else
    hard_dec = (h == 2'd0) ? 2'd0 : h - 2'd1;
`endif
  endfunction

  logic [NBTN-1:0]   raw;
  logic [DB_LEN-1:0] shift_p0 [NBTN];
  logic [NBTN-1:0]   level;
  logic [NBTN-1:0]   prev_p1;
  logic [NBTN-1:0]   press;

  state_t     state_q, state_d;
  logic       up_q, up_d;
  logic       speed_q, speed_d;
  logic [1:0] hard_q, hard_d;
  logic       start_q, start_d;

  assign raw[B_ENTER] = bus.btn_enter;
  assign raw[B_UP]    = bus.btn_up;
  assign raw[B_DOWN]  = bus.btn_down;
  assign raw[B_LEFT]  = bus.btn_left;
  assign raw[B_RIGHT] = bus.btn_right;

  // Debounce stage: shift each raw button into its own sample history
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBTN; i++) shift_p0[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++)
        shift_p0[i] <= {shift_p0[i][DB_LEN-2:0], raw[i]};
    end
  end

  // A level is accepted only once every sample in the history is high;
  // the press event is its rising edge against the registered level.
  always_comb begin
    level = '0;
    press = '0;
    for (int i = 0; i < NBTN; i++) begin
      level[i] = &shift_p0[i];
      press[i] = level[i] & ~prev_p1[i];
    end
  end

  // Edge-detect stage: remember last cycle's debounced level
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) prev_p1 <= '0;
    else     prev_p1 <= level;
  end

  // Page state and settings register; everything the outputs see is here
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      state_q <= ST_MENU;
      up_q    <= 1'b0;
      speed_q <= 1'b0;
      hard_q  <= 2'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      speed_q <= speed_d;
      hard_q  <= hard_d;
      start_q <= start_d;
    end
  end

  // Next-state logic: one action per cycle, taken from the highest-priority
  // press event; the if/else chain order is the priority order.
  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    speed_d = speed_q;
    hard_d  = hard_q;
    start_d = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (press[B_ENTER]) begin
          state_d = ST_PLAY;
          start_d = 1'b1;
        end else if (press[B_UP]) begin
          up_d = 1'b0;
        end else if (press[B_DOWN]) begin
          up_d = 1'b1;
        end else if (press[B_LEFT]) begin
          if (up_q) speed_d = ~speed_q;
          else      hard_d  = hard_dec(hard_q);
        end else if (press[B_RIGHT]) begin
          if (up_q) speed_d = ~speed_q;
          else      hard_d  = hard_inc(hard_q);
        end
      end
      ST_PLAY: begin
        // Buttons are ignored and settings frozen while a round runs
        if (bus.game_over) state_d = ST_OVER;
      end
      ST_OVER: begin
        if (press[B_ENTER]) begin
          state_d = ST_MENU;
          up_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_MENU;
      end
    endcase
  end

  assign bus.page  = state_q;
  assign bus.up    = up_q;
  assign bus.speed = speed_q;
  assign bus.hard  = hard_q;
  assign bus.start = start_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with DB_LEN = 4.
// Inputs change just after the falling edge; outputs are sampled on the
// following falling edge, half a period after the rising edge.
module tb_menu_ctrl;

  logic clk_22 = 1'b0;
  logic rst    = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  menu_ctrl_if bus ();

  menu_ctrl #(.DB_LEN(4)) dut (
    .clk_22 (clk_22),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_22 = ~clk_22;

`ifdef MENU_CTRL_HARD_WRAP_EN
  localparam logic [7:0] R3 = 8'd0;
  localparam logic [7:0] L1 = 8'd2;
  localparam logic [7:0] L2 = 8'd1;
`else
  localparam logic [7:0] R3 = 8'd2;
  localparam logic [7:0] L1 = 8'd1;
  localparam logic [7:0] L2 = 8'd0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_22);
  endtask

  // 0=enter 1=up 2=down 3=left 4=right
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_enter = v;
      1: bus.btn_up    = v;
      2: bus.btn_down  = v;
      3: bus.btn_left  = v;
      default: bus.btn_right = v;
    endcase
  endtask

  task automatic press(input int b, input int hi, input int lo);
    set_btn(b, 1'b1);
    step(hi);
    set_btn(b, 1'b0);
    step(lo);
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_page,
                           input logic [7:0] e_up, input logic [7:0] e_speed,
                           input logic [7:0] e_hard, input logic [7:0] e_start);
    check({tag, ".page"},  {6'd0, bus.page},  e_page);
    check({tag, ".up"},    {7'd0, bus.up},    e_up);
    check({tag, ".speed"}, {7'd0, bus.speed}, e_speed);
    check({tag, ".hard"},  {6'd0, bus.hard},  e_hard);
    check({tag, ".start"}, {7'd0, bus.start}, e_start);
  endtask

  initial begin
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0;
    bus.btn_right = 0; bus.btn_enter = 0; bus.game_over = 0;
    step(3);
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1);

    // Held down button: fires once on edge 5, then nothing more
    bus.btn_down = 1'b1;
    step(4);
    check("down_edge4", {7'd0, bus.up}, 8'd0);
    step(1);
    check("down_edge5", {7'd0, bus.up}, 8'd1);
    step(20);
    check("down_held", {7'd0, bus.up}, 8'd1);
    bus.btn_down = 1'b0;
    step(2);

    press(1, 6, 2);
    check("up_press", {7'd0, bus.up}, 8'd0);

    // Difficulty ends: three rights then three lefts
    press(4, 6, 2); check("hard_r1", {6'd0, bus.hard}, 8'd1);
    press(4, 6, 2); check("hard_r2", {6'd0, bus.hard}, 8'd2);
    press(4, 6, 2); check("hard_r3", {6'd0, bus.hard}, R3);
    press(3, 6, 2); check("hard_l1", {6'd0, bus.hard}, L1);
    press(3, 6, 2); check("hard_l2", {6'd0, bus.hard}, L2);
    press(3, 6, 2); check("hard_l3", {6'd0, bus.hard}, 8'd0);
    press(4, 6, 2); check("hard_r4", {6'd0, bus.hard}, 8'd1);

    // Speed row: left/right toggle speed, hard untouched
    press(2, 6, 2); check("down_row", {7'd0, bus.up}, 8'd1);
    press(4, 6, 2); check("spd_r", {7'd0, bus.speed}, 8'd1);
    press(3, 6, 2); check("spd_l", {7'd0, bus.speed}, 8'd0);
    press(4, 6, 2); check_all("spd_r2", 0, 1, 1, 1, 0);

    // Enter and left together: enter wins, left discarded
    bus.btn_enter = 1'b1; bus.btn_left = 1'b1;
    step(4);
    check("enter_early", {6'd0, bus.page}, 8'd0);
    step(1);
    check_all("enter_go", 1, 1, 1, 1, 1);
    step(1);
    check_all("enter_after", 1, 1, 1, 1, 0);
    bus.btn_enter = 1'b0; bus.btn_left = 1'b0;
    step(2);

    // PLAY ignores buttons
    press(4, 6, 2);
    press(2, 6, 2);
    press(1, 6, 2);
    check_all("play_frozen", 1, 1, 1, 1, 0);
    bus.game_over = 1'b1;
    step(1);
    check("game_over", {6'd0, bus.page}, 8'd2);
    press(4, 6, 2);
    check_all("over_ignore", 2, 1, 1, 1, 0);
    press(0, 6, 2);
    check_all("over_exit", 0, 0, 1, 1, 0);
    step(3);
    check("menu_ignores_go", {6'd0, bus.page}, 8'd0);
    bus.game_over = 1'b0;

    // Short glitch gives no event
    press(4, 6, 2); check("hard_to2", {6'd0, bus.hard}, 8'd2);
    press(2, 6, 2); check("up_to1", {7'd0, bus.up}, 8'd1);
    press(1, 3, 3); check("glitch", {7'd0, bus.up}, 8'd1);
    press(0, 6, 2); check_all("play2", 1, 1, 1, 2, 0);

    // Asynchronous reset mid-PLAY with presses pending
    bus.btn_enter = 1'b1; bus.btn_down = 1'b1;
    step(2);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    step(4);
    check("held_edge4", {6'd0, bus.page}, 8'd0);
    step(1);
    check_all("held_fire", 1, 0, 0, 0, 1);
    bus.btn_enter = 1'b0; bus.btn_down = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
